// File: rtl/spi_master_lite.sv
// Single-channel SPI master (mode 0): one request in, one response out.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB-first; default build is MSB-first.
module spi_master_lite #(
    parameter int MAX_LEN = 16,
    parameter int DIV_W   = 8,
    parameter int SS_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MAX_LEN-1:0]       req_data,
    input  logic [$clog2(MAX_LEN):0] req_len,
    input  logic [DIV_W-1:0]         req_div,
    input  logic [SS_W-1:0]          req_ss,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [MAX_LEN-1:0]       resp_data,
    output logic                     sck,
    output logic [SS_W-1:0]          ss,
    output logic                     mosi,
    input  logic                     miso
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   bits_q, bits_d;
    logic [MAX_LEN-1:0] tx_q, tx_d;
    logic [MAX_LEN-1:0] rx_q, rx_d;
    logic               sck_q, sck_d;
    logic [SS_W-1:0]    ss_q, ss_d;
    logic               mosi_q, mosi_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic [MAX_LEN-1:0] top_q, top_d;
`endif

    logic [LEN_W-1:0]   len_c;
    logic [MAX_LEN-1:0] tx_load;
    logic               phase_done;

    assign len_c      = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;
    assign phase_done = (cnt_q == '0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_load = req_data;
`else
    // Left-justify so the next bit to send always sits in the MSB.
    assign tx_load = req_data << (MAX_LEN_L - len_c);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            ss_q    <= '1;
            mosi_q  <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            top_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
            top_q   <= top_d;
`endif
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bits_d  = bits_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
        top_d   = top_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    div_d  = req_div;
                    rx_d   = '0;
                    bits_d = len_c;
                    if (len_c == '0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = req_div;
                        ss_d    = ~req_ss;
                        tx_d    = tx_load;
`ifdef SPI_MASTER_LSB_FIRST_EN
                        mosi_d  = tx_load[0];
                        top_d   = MAX_LEN'(1) << (len_c - LEN_W'(1));
`else
                        mosi_d  = tx_load[MAX_LEN-1];
`endif
                    end
                end
            end

            S_SETUP: begin
                if (phase_done) begin
                    state_d = S_HIGH;
                    sck_d   = 1'b1;
                    cnt_d   = div_q;
                end else begin
                    cnt_d   = cnt_q - DIV_W'(1);
                end
            end

            S_HIGH: begin
                if (phase_done) begin
                    // Falling edge: sample miso (slave updated it on the rising
                    // edge) and present the next bit for the coming rise.
                    state_d = S_LOW;
                    sck_d   = 1'b0;
                    cnt_d   = div_q;
                    bits_d  = bits_q - LEN_W'(1);
`ifdef SPI_MASTER_LSB_FIRST_EN
                    rx_d    = (rx_q >> 1) | (miso ? top_q : '0);
                    if (bits_q != LEN_W'(1)) begin
                        tx_d   = tx_q >> 1;
                        mosi_d = tx_q[1];
                    end
`else
                    rx_d    = {rx_q[MAX_LEN-2:0], miso};
                    if (bits_q != LEN_W'(1)) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[MAX_LEN-2];
                    end
`endif
                end else begin
                    cnt_d   = cnt_q - DIV_W'(1);
                end
            end

            S_LOW: begin
                if (phase_done) begin
                    cnt_d = div_q;
                    if (bits_q == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_HIGH;
                        sck_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            S_HOLD: begin
                if (phase_done) begin
                    state_d = S_RESP;
                    ss_d    = '1;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q - DIV_W'(1);
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = rx_q;
    assign sck        = sck_q;
    assign ss         = ss_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master_lite.sv
// Directed bench for spi_master_lite: vector table of transfers plus
// hand-written stall and mid-transfer reset sequences.
module tb_spi_master_lite;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [15:0] req_data = '0;
    logic [4:0]  req_len = '0;
    logic [7:0]  req_div = '0;
    logic [7:0]  req_ss = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        sck;
    logic [7:0]  ss;
    logic        mosi;
    logic        miso;

    // Bit-reversal slave on ss[0]: ones during the first byte, then the
    // captured byte bit-reversed, MSB-first, updated on sck rising edges.
    logic        use_rev = 1'b0;
    logic        miso_tb = 1'b1;
    logic [7:0]  rev_c = '0;
    int          rev_n = 0;

    assign miso = use_rev ? miso_tb : mosi;

    always @(posedge sck or posedge ss[0]) begin
        if (ss[0]) begin
            rev_n   = 0;
            miso_tb = 1'b1;
        end else begin
            rev_n = rev_n + 1;
            if (rev_n <= 8) begin
                rev_c   = {rev_c[6:0], mosi};
                miso_tb = 1'b1;
            end else if (rev_n <= 16) begin
                miso_tb = rev_c[rev_n-9];
            end
        end
    end

    spi_master_lite #(.MAX_LEN(16), .DIV_W(8), .SS_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_len    (req_len),
        .req_div    (req_div),
        .req_ss     (req_ss),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .sck        (sck),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [4:0]  len;
        logic [7:0]  div;
        logic [7:0]  ssel;
        bit          rev;
        logic [15:0] exp_data;
        int          exp_cyc;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [8];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [15:0] d, input logic [4:0] l,
                                input logic [7:0] dv, input logic [7:0] s, input bit r,
                                input logic [15:0] e, input int c, input int p);
        vec_t v;
        v.name = nm; v.data = d; v.len = l; v.div = dv; v.ssel = s; v.rev = r;
        v.exp_data = e; v.exp_cyc = c; v.exp_pulses = p;
        return v;
    endfunction

    // Latency counts clock edges from the handshake edge (inclusive) until
    // resp_valid is seen: 1 + (div+1)*(2*len+2) for len >= 1, 1 for len == 0.
    task automatic run_xfer(input vec_t v, input bit stall);
        int          cyc, rises, run_len, ss_bad, n;
        int          hi_min, hi_max, lo_min, lo_max;
        logic        run_lvl, seen_fall, ss_touched;
        logic [15:0] act_mosi;
        logic [31:0] mask;

        n = (v.len > 5'd16) ? 16 : int'(v.len);
        mask = (32'h1 << n) - 32'h1;
        use_rev = v.rev;

        @(negedge clock);
        check({v.name, "/req_ready"}, 32'(req_ready), 32'h1);
        req_data  = v.data;
        req_len   = v.len;
        req_div   = v.div;
        req_ss    = v.ssel;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = ~v.data;
        req_len   = 5'd3;
        req_div   = 8'd0;
        req_ss    = 8'hFF;

        cyc = 1; rises = 0; run_len = 0; ss_bad = 0;
        hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
        run_lvl = 1'b0; seen_fall = 1'b0; ss_touched = 1'b0; act_mosi = '0;
        while (1) begin
            if (ss !== 8'hFF) ss_touched = 1'b1;
            if (sck === run_lvl) begin
                run_len++;
            end else begin
                if (run_lvl) begin
                    if (run_len < hi_min) hi_min = run_len;
                    if (run_len > hi_max) hi_max = run_len;
                    seen_fall = 1'b1;
                end else if (seen_fall) begin
                    if (run_len < lo_min) lo_min = run_len;
                    if (run_len > lo_max) lo_max = run_len;
                end
                if (sck) begin
                    rises++;
                    act_mosi = {act_mosi[14:0], mosi};
                    if (ss !== ~v.ssel) ss_bad++;
                end
                run_lvl = sck;
                run_len = 1;
            end
            if (resp_valid || cyc >= 3000) break;
            @(negedge clock);
            cyc++;
        end

        check({v.name, "/latency"}, 32'(cyc), 32'(v.exp_cyc));
        check({v.name, "/resp_data"}, 32'(resp_data), 32'(v.exp_data));
        check({v.name, "/sck_pulses"}, 32'(rises), 32'(v.exp_pulses));
        check({v.name, "/mosi_bits"}, 32'(act_mosi), 32'(v.data) & mask);
        check({v.name, "/end_sck"}, 32'(sck), 32'h0);
        check({v.name, "/end_ss"}, 32'(ss), 32'hFF);
        if (n == 0) check({v.name, "/ss_untouched"}, 32'(ss_touched), 32'h0);
        else        check({v.name, "/ss_select"}, 32'(ss_bad), 32'h0);
        if (rises >= 1) begin
            check({v.name, "/high_min"}, 32'(hi_min), 32'(v.div) + 32'h1);
            check({v.name, "/high_max"}, 32'(hi_max), 32'(v.div) + 32'h1);
        end
        if (rises >= 2) begin
            check({v.name, "/low_min"}, 32'(lo_min), 32'(v.div) + 32'h1);
            check({v.name, "/low_max"}, 32'(lo_max), 32'(v.div) + 32'h1);
        end

        if (stall) begin
            // A competing request during the stall must be ignored.
            for (int k = 0; k < 5; k++) begin
                req_valid = 1'b1;
                req_data  = 16'h1234;
                req_len   = 5'd8;
                req_ss    = 8'h02;
                @(negedge clock);
                check({v.name, "/stall_valid"}, 32'(resp_valid), 32'h1);
                check({v.name, "/stall_data"}, 32'(resp_data), 32'(v.exp_data));
                check({v.name, "/stall_ready"}, 32'(req_ready), 32'h0);
            end
            req_valid = 1'b0;
        end

        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check({v.name, "/consumed"}, 32'(resp_valid), 32'h0);
        check({v.name, "/back_idle"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        int   rises, cyc;
        logic prev, seen;

        vecs[0] = mk("loop_a5",    16'h00A5, 5'd8,  8'd0, 8'h01, 1'b0, 16'h00A5, 19,  8);
        vecs[1] = mk("bitrev_a5",  16'hA500, 5'd16, 8'd3, 8'h01, 1'b1, 16'hFFA5, 137, 16);
        vecs[2] = mk("len0",       16'h00FF, 5'd0,  8'd0, 8'h01, 1'b0, 16'h0000, 1,   0);
        vecs[3] = mk("len20_clip", 16'hFFFF, 5'd20, 8'd0, 8'h01, 1'b0, 16'hFFFF, 35,  16);
        vecs[4] = mk("bitrev_13",  16'h1300, 5'd16, 8'd1, 8'h01, 1'b1, 16'hFFC8, 69,  16);
        vecs[5] = mk("len1_div2",  16'h0001, 5'd1,  8'd2, 8'h04, 1'b0, 16'h0001, 13,  1);
        vecs[6] = mk("len5_mask",  16'hFFF6, 5'd5,  8'd0, 8'h10, 1'b0, 16'h0016, 13,  5);
        vecs[7] = mk("ss_81",      16'h003C, 5'd8,  8'd0, 8'h81, 1'b0, 16'h003C, 19,  8);

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("reset/sck", 32'(sck), 32'h0);
        check("reset/ss", 32'(ss), 32'hFF);
        check("reset/mosi", 32'(mosi), 32'h0);
        check("reset/req_ready", 32'(req_ready), 32'h1);
        check("reset/resp_valid", 32'(resp_valid), 32'h0);
        check("reset/resp_data", 32'(resp_data), 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i], i == 3);
        end

        // Reset after the 5th rising sck edge aborts with no response.
        use_rev = 1'b0;
        @(negedge clock);
        req_data = 16'hFFFF; req_len = 5'd16; req_div = 8'd1; req_ss = 8'h01;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        rises = 0; cyc = 0; prev = 1'b0;
        while (rises < 5 && cyc < 500) begin
            @(negedge clock);
            cyc++;
            if (sck && !prev) rises++;
            prev = sck;
        end
        check("abort/reach_5th_edge", 32'(rises), 32'd5);
        reset = 1'b1;
        @(negedge clock);
        check("abort/sck", 32'(sck), 32'h0);
        check("abort/ss", 32'(ss), 32'hFF);
        check("abort/mosi", 32'(mosi), 32'h0);
        check("abort/resp_valid", 32'(resp_valid), 32'h0);
        check("abort/resp_data", 32'(resp_data), 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (resp_valid || sck || ss !== 8'hFF) seen = 1'b1;
        end
        check("abort/quiet_after", 32'(seen), 32'h0);
        run_xfer(mk("after_abort", 16'h003C, 5'd8, 8'd0, 8'h01, 1'b0, 16'h003C, 19, 8), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
